// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports, NWR write
// ports, hardwired-zero x0, optional same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int unsigned XW     = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD-1:0]    rd_en_ip,
  input  logic [NRD*AW-1:0] rd_addr_ip,
  output logic [NRD*XW-1:0] rd_data_op,
  input  logic [NWR-1:0]    wr_en_ip,
  input  logic [NWR*AW-1:0] wr_addr_ip,
  input  logic [NWR*XW-1:0] wr_data_ip
);

  // x0 has no storage; entries 1..NREGS-1 only
  logic [XW-1:0] regs [1:NREGS-1];

  // value each read port will load at the next edge
  logic [XW-1:0] rd_next [NRD];

  // storage update; later ports assign last so the higher index wins a conflict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < int'(NREGS); r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < int'(NWR); w++) begin
        if (wr_en_ip[w] && (wr_addr_ip[w*AW +: AW] != '0)) begin
          regs[wr_addr_ip[w*AW +: AW]] <= wr_data_ip[w*XW +: XW];
        end
      end
    end
  end

  // read mux: x0 forced to zero, then stored value, then optional bypass
  always_comb begin
    for (int p = 0; p < int'(NRD); p++) begin
      rd_next[p] = '0;
      if (rd_addr_ip[p*AW +: AW] != '0) begin
        rd_next[p] = regs[rd_addr_ip[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int w = 0; w < int'(NWR); w++) begin
            if (wr_en_ip[w] && (wr_addr_ip[w*AW +: AW] == rd_addr_ip[p*AW +: AW])) begin
              rd_next[p] = wr_data_ip[w*XW +: XW];
            end
          end
        end
      end
    end
  end

  // registered read outputs; a disabled port holds its last value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_op <= '0;
    end else begin
      for (int p = 0; p < int'(NRD); p++) begin
        if (rd_en_ip[p]) begin
          rd_data_op[p*XW +: XW] <= rd_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 4-read/2-write bypassed
// instance and a 2-read/1-write non-bypassed instance share clock and reset.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // instance A: NRD=4, NWR=2, BYPASS=1
  logic [3:0]   a_rd_en;
  logic [19:0]  a_rd_addr;
  logic [127:0] a_rd_data;
  logic [1:0]   a_wr_en;
  logic [9:0]   a_wr_addr;
  logic [63:0]  a_wr_data;

  // instance B: NRD=2, NWR=1, BYPASS=0
  logic [1:0]   b_rd_en;
  logic [9:0]   b_rd_addr;
  logic [63:0]  b_rd_data;
  logic [0:0]   b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [31:0]  b_wr_data;

  int checks;
  int failures;

  regfile_mp #(.XW(32), .NREGS(32), .NRD(4), .NWR(2), .BYPASS(1)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_ip   (a_rd_en),
    .rd_addr_ip (a_rd_addr),
    .rd_data_op (a_rd_data),
    .wr_en_ip   (a_wr_en),
    .wr_addr_ip (a_wr_addr),
    .wr_data_ip (a_wr_data)
  );

  regfile_mp #(.XW(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_ip   (b_rd_en),
    .rd_addr_ip (b_rd_addr),
    .rd_data_op (b_rd_data),
    .wr_en_ip   (b_wr_en),
    .wr_addr_ip (b_wr_addr),
    .wr_data_ip (b_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ard(input int p);
    return a_rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] brd(input int p);
    return b_rd_data[p*32 +: 32];
  endfunction

  task automatic a_rd(input int p, input int addr);
    a_rd_en[p] = 1'b1;
    a_rd_addr[p*5 +: 5] = 5'(addr);
  endtask

  task automatic a_wr(input int w, input int addr, input logic [31:0] data);
    a_wr_en[w] = 1'b1;
    a_wr_addr[w*5 +: 5] = 5'(addr);
    a_wr_data[w*32 +: 32] = data;
  endtask

  task automatic idle();
    a_rd_en = '0; a_wr_en = '0;
    b_rd_en = '0; b_wr_en = '0;
  endtask

  initial begin
    logic [31:0] exp;
    int addr;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a_rd_en = '0; a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = '0; b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    step();
    step();
    for (int p = 0; p < 4; p++) chk($sformatf("reset_a%0d", p), ard(p), 32'h0);
    for (int p = 0; p < 2; p++) chk($sformatf("reset_b%0d", p), brd(p), 32'h0);

    // reset clears stored data
    rst_n = 1'b1;
    a_wr(0, 5, 32'hDEADBEEF);
    step();
    idle();
    a_rd(0, 5);
    step();
    chk("x5_written", ard(0), 32'hDEADBEEF);
    rst_n = 1'b0;
    for (int p = 0; p < 4; p++) a_rd(p, 5);
    step();
    for (int p = 0; p < 4; p++) chk($sformatf("in_reset_a%0d", p), ard(p), 32'h0);
    rst_n = 1'b1;
    step();
    for (int p = 0; p < 4; p++) chk($sformatf("x5_after_reset_a%0d", p), ard(p), 32'h0);

    // x0 protection, with bypass active
    idle();
    a_wr(0, 0, 32'hFFFFFFFF);
    a_wr(1, 0, 32'hFFFFFFFF);
    a_rd(0, 0);
    a_rd(1, 0);
    step();
    chk("x0_same_cycle_p0", ard(0), 32'h0);
    chk("x0_same_cycle_p1", ard(1), 32'h0);
    idle();
    a_rd(0, 0);
    step();
    chk("x0_next_cycle", ard(0), 32'h0);

    // bypass on A, no bypass on B
    idle();
    a_wr(0, 7, 32'h12345678);
    a_rd(0, 7); a_rd(1, 7); a_rd(2, 8);
    b_wr_en = 1'b1; b_wr_addr = 5'd7; b_wr_data = 32'h12345678;
    b_rd_en = 2'b11; b_rd_addr = {5'd7, 5'd7};
    step();
    chk("bypass_a_p0", ard(0), 32'h12345678);
    chk("bypass_a_p1", ard(1), 32'h12345678);
    chk("bypass_other_addr", ard(2), 32'h0);
    chk("nobypass_b_p0", brd(0), 32'h0);
    chk("nobypass_b_p1", brd(1), 32'h0);
    idle();
    b_rd_en = 2'b11;
    step();
    chk("nobypass_reread_p0", brd(0), 32'h12345678);
    chk("nobypass_reread_p1", brd(1), 32'h12345678);

    // write conflict: higher-index write port wins
    idle();
    a_wr(0, 3, 32'h11111111);
    a_wr(1, 3, 32'h22222222);
    a_rd(2, 3);
    step();
    chk("conflict_bypass", ard(2), 32'h22222222);
    idle();
    a_rd(3, 3);
    step();
    chk("conflict_stored", ard(3), 32'h22222222);

    // stall hold on port 0
    idle();
    a_wr(0, 4, 32'hA5A5A5A5);
    step();
    idle();
    a_rd(0, 4);
    step();
    chk("stall_read", ard(0), 32'hA5A5A5A5);
    idle();
    a_rd_addr[4:0] = 5'd4;
    a_wr(1, 4, 32'h5A5A5A5A);
    step();
    chk("stall_hold", ard(0), 32'hA5A5A5A5);
    idle();
    a_rd(0, 4);
    step();
    chk("stall_release", ard(0), 32'h5A5A5A5A);
    idle();
    rst_n = 1'b0;
    step();
    chk("reset_mid_stall", ard(0), 32'h0);
    rst_n = 1'b1;

    // full sweep: x1..x31 written, read back at varied addresses on all ports
    idle();
    for (int i = 1; i < 32; i++) begin
      a_wr(0, i, 32'(i) * 32'h01010101);
      step();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 4; p++) a_rd(p, (k*5 + p*9) % 32);
      step();
      for (int p = 0; p < 4; p++) begin
        addr = (k*5 + p*9) % 32;
        exp = (addr == 0) ? 32'h0 : 32'(addr) * 32'h01010101;
        chk($sformatf("sweep_k%0d_p%0d_x%0d", k, p, addr), ard(p), exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
